forwarding_hazard_unit: RTL

//  Parametrised successor to the EX-stage forwarding unit. Tracks in-flight destination registers in a

---
 rtl/pipe_pkg.sv | 10 +
 rtl/forwarding_hazard_unit_if.sv | 29 ++
 rtl/fwd_operand_match.sv | 39 +++
 rtl/forwarding_hazard_unit.sv | 69 ++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and helpers for the forwarding/hazard scoreboard.
package pipe_pkg;
    localparam int REG_AW_DEF = 5;
    localparam int FWD_RF     = 0;

    // Scoreboard entry width: {valid, rd, reg_write, mem_read}
    function automatic int entry_w(input int aw);
        return aw + 3;
    endfunction
endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// forwarding_hazard_unit_if: ID-side issue/operand bus and the forwarding/stall responses.
interface forwarding_hazard_unit_if
    import pipe_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3
);
    localparam int SW = $clog2(DEPTH + 1);
    logic                      flush;
    logic                      issue_valid;
    logic [REG_AW-1:0]         issue_rd;
    logic                      issue_reg_write;
    logic                      issue_mem_read;
    logic [NUM_SRC*REG_AW-1:0] src_addr;
    logic [NUM_SRC-1:0]        src_used;
    logic [NUM_SRC*SW-1:0]     fwd_sel;
    logic                      stall;
    logic [15:0]               stall_cnt;

    modport master (
        output flush, issue_valid, issue_rd, issue_reg_write, issue_mem_read, src_addr, src_used,
        input  fwd_sel, stall, stall_cnt
    );
    modport slave (
        input  flush, issue_valid, issue_rd, issue_reg_write, issue_mem_read, src_addr, src_used,
        output fwd_sel, stall, stall_cnt
    );
endinterface

// File: rtl/fwd_operand_match.sv
// fwd_operand_match: priority-encodes the youngest scoreboard writer of one source operand
// and flags it when that writer is a load whose data is not yet forwardable.
module fwd_operand_match
    import pipe_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 1
) (
    input  logic [DEPTH-1:0][REG_AW+2:0]  ent,
    input  logic [REG_AW-1:0]             src_addr,
    input  logic                          src_used,
    output logic [$clog2(DEPTH+1)-1:0]    fwd_sel,
    output logic                          load_hazard
);
    localparam int SW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
    } entry_t;

    entry_t [DEPTH-1:0] e;
    assign e = ent;

    // Scan oldest to youngest so the youngest match overwrites older ones
    always_comb begin
        fwd_sel     = SW'(FWD_RF);
        load_hazard = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (e[k].valid && e[k].reg_write && e[k].rd == src_addr && e[k].rd != '0 && src_used) begin
                fwd_sel     = SW'(k + 1);
                load_hazard = e[k].mem_read && (k < LOAD_READY);
            end
        end
    end
endmodule

// File: rtl/forwarding_hazard_unit.sv
// forwarding_hazard_unit: DEPTH-entry destination scoreboard driving per-operand forwarding
// selects, load-use stall with bubble insertion, flush and a saturating stall counter.
module forwarding_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 1
) (
    input logic                     clk,
    input logic                     rst,
    forwarding_hazard_unit_if.slave bus
);
    localparam int SW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
    } entry_t;

    entry_t [DEPTH-1:0]    sb_q, sb_d;
    logic [15:0]           stall_cnt_q, stall_cnt_d;
    logic [NUM_SRC-1:0]    haz;
    logic [NUM_SRC*SW-1:0] fwd_sel;
    logic                  stall;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_operand_match #(
            .REG_AW     (REG_AW),
            .DEPTH      (DEPTH),
            .LOAD_READY (LOAD_READY)
        ) u_match (
            .ent         (sb_q),
            .src_addr    (bus.src_addr[i*REG_AW +: REG_AW]),
            .src_used    (bus.src_used[i]),
            .fwd_sel     (fwd_sel[i*SW +: SW]),
            .load_hazard (haz[i])
        );
    end

    // Flush outranks stall, and a stalled or flushed issue becomes a bubble
    always_comb begin
        stall       = bus.issue_valid && |haz && !bus.flush;
        sb_d        = '0;
        sb_d[0]     = (bus.issue_valid && !stall && !bus.flush) ?
                      entry_t'{valid: 1'b1, rd: bus.issue_rd, reg_write: bus.issue_reg_write,
                               mem_read: bus.issue_mem_read} : '0;
        for (int k = 1; k < DEPTH; k++)
            sb_d[k] = bus.flush ? '0 : sb_q[k-1];
        stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            sb_q        <= sb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.fwd_sel   = fwd_sel;
    assign bus.stall     = stall;
    assign bus.stall_cnt = stall_cnt_q;
endmodule
